// File: rtl/dma_ahb_regbank.sv
// dma_ahb_regbank - AHB-Lite slave register bank for the DMA controller.
// Channel n at BASE_ADDR+16n: CTRL(+0) SRC(+4) DST(+8) STATUS(+C, read-only).
// Optional interrupt block (INT_STAT/INT_MASK at BASE_ADDR+16*NUM_CH, irq)
// is built when the macro DMA_REG_IRQ_EN is defined.
module dma_ahb_regbank #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned SIZE_W    = 10
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic                     HSEL,
  input  logic                     HREADY,
  input  logic [1:0]               HTRANS,
  input  logic [2:0]               HSIZE,
  input  logic                     HWRITE,
  input  logic [31:0]              HADDR,
  input  logic [31:0]              HWDATA,
  output logic                     HREADYOUT,
  output logic                     HRESP,
  output logic [31:0]              HRDATA,
  output logic [NUM_CH-1:0]        ch_en,
  output logic [NUM_CH-1:0]        ch_target,
  output logic [NUM_CH*SIZE_W-1:0] ch_size,
  output logic [NUM_CH*32-1:0]     ch_sour,
  output logic [NUM_CH*32-1:0]     ch_dest,
  input  logic [NUM_CH-1:0]        ch_done,
  input  logic [NUM_CH-1:0]        ch_err,
  output logic                     irq
);

  localparam int unsigned NWORDS = 4 * NUM_CH;

  typedef enum logic [1:0] {OK, ERR1, ERR2} resp_t;
  resp_t state, state_nx;

  logic [31:0] ctrl_q [NUM_CH];
  logic [31:0] src_q  [NUM_CH];
  logic [31:0] dst_q  [NUM_CH];
  logic [1:0]  stat_q [NUM_CH];

`ifdef DMA_REG_IRQ_EN
  logic [NUM_CH-1:0] int_stat_q, int_mask_q, w1c;
  logic              wr_istat, wr_imask;
`endif

  logic        access, mapped, misalign, bad, stall;
  logic [29:0] offw;
  logic [5:0]  idx;
  logic [3:0]  strb;
  logic [31:0] rd_val;

  logic        dp_wr;
  logic [5:0]  dp_idx;
  logic [3:0]  dp_strb;
  logic [29:0] dp_word;
  logic [31:0] wmask;

  logic [NUM_CH-1:0] wr_ctrl, wr_src, wr_dst, ev;

  logic unused_bits;
  assign unused_bits = HTRANS[0];

  // Address-phase decode: word offset, mapping, error and byte strobes.
  always_comb begin
    access   = HSEL & HTRANS[1] & HREADY;
    offw     = HADDR[31:2] - BASE_ADDR[31:2];
    idx      = offw[5:0];
    mapped   = offw < 30'(NWORDS);
`ifdef DMA_REG_IRQ_EN
    mapped   = mapped | (offw == 30'(NWORDS)) | (offw == 30'(NWORDS + 1));
`endif
    misalign = ((HSIZE == 3'd1) & HADDR[0]) |
               ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
    bad      = !mapped | (HSIZE > 3'd2) | misalign;
    case (HSIZE)
      3'd0:    strb = 4'b0001 << HADDR[1:0];
      3'd1:    strb = HADDR[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    // A read may not overtake a pending write to the same word.
    stall = (state == OK) & dp_wr & HSEL & HTRANS[1] & !HWRITE &
            (HADDR[31:2] == dp_word);
  end

  // Read multiplexer on the address-phase word index.
  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (idx == 6'(4 * i))     rd_val = ctrl_q[i];
      if (idx == 6'(4 * i + 1)) rd_val = src_q[i];
      if (idx == 6'(4 * i + 2)) rd_val = dst_q[i];
      if (idx == 6'(4 * i + 3)) rd_val = {30'b0, stat_q[i]};
    end
`ifdef DMA_REG_IRQ_EN
    if (idx == 6'(NWORDS))     rd_val = 32'(int_stat_q);
    if (idx == 6'(NWORDS + 1)) rd_val = 32'(int_mask_q);
`endif
  end

  // Data-phase write targets and engine events per channel.
  always_comb begin
    wmask   = {{8{dp_strb[3]}}, {8{dp_strb[2]}}, {8{dp_strb[1]}}, {8{dp_strb[0]}}};
    wr_ctrl = '0;
    wr_src  = '0;
    wr_dst  = '0;
    ev      = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_ctrl[i] = dp_wr & (dp_idx == 6'(4 * i));
      wr_src[i]  = dp_wr & (dp_idx == 6'(4 * i + 1));
      wr_dst[i]  = dp_wr & (dp_idx == 6'(4 * i + 2));
      ev[i]      = ch_done[i] | ch_err[i];
    end
  end

  // Response state register.
  always_ff @(posedge HCLK) begin
    if (HRESET) state <= OK;
    else        state <= state_nx;
  end

  // Response next-state and bus handshake outputs.
  always_comb begin
    state_nx  = state;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      OK: begin
        HREADYOUT = !stall;
        if (access && bad) state_nx = ERR1;
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_nx  = ERR2;
      end
      ERR2: begin
        HRESP    = 1'b1;
        state_nx = (access && bad) ? ERR1 : OK;
      end
      default: state_nx = OK;
    endcase
  end

  // Address-phase capture and registered read data.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_wr   <= 1'b0;
      dp_idx  <= '0;
      dp_strb <= '0;
      dp_word <= '0;
      HRDATA  <= '0;
    end else begin
      dp_wr <= access & HWRITE & !bad;
      if (access) begin
        dp_idx  <= idx;
        dp_strb <= strb;
        dp_word <= HADDR[31:2];
        if (!HWRITE) HRDATA <= bad ? '0 : rd_val;
      end
    end
  end

  // Channel registers: bus byte writes, engine done/err events.
  always_ff @(posedge HCLK) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (HRESET) begin
        ctrl_q[i] <= '0;
        src_q[i]  <= '0;
        dst_q[i]  <= '0;
        stat_q[i] <= '0;
      end else begin
        if (wr_ctrl[i])  ctrl_q[i]    <= (ctrl_q[i] & ~wmask) | (HWDATA & wmask);
        else if (ev[i])  ctrl_q[i][0] <= 1'b0;
        if (wr_src[i])   src_q[i]     <= (src_q[i] & ~wmask) | (HWDATA & wmask);
        if (wr_dst[i])   dst_q[i]     <= (dst_q[i] & ~wmask) | (HWDATA & wmask);
        // Enabling clears status, but an event in the same cycle still sets it.
        if (wr_ctrl[i] && dp_strb[0] && HWDATA[0])
          stat_q[i] <= {ch_err[i], ch_done[i]};
        else
          stat_q[i] <= stat_q[i] | {ch_err[i], ch_done[i]};
      end
    end
  end

  // Configuration outputs unpacked from the channel registers.
  always_comb begin
    ch_en     = '0;
    ch_target = '0;
    ch_size   = '0;
    ch_sour   = '0;
    ch_dest   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_en[i]                     = ctrl_q[i][0];
      ch_target[i]                 = ctrl_q[i][4];
      ch_size[i*SIZE_W +: SIZE_W]  = ctrl_q[i][8 +: SIZE_W];
      ch_sour[i*32 +: 32]          = src_q[i];
      ch_dest[i*32 +: 32]          = dst_q[i];
    end
  end

`ifdef DMA_REG_IRQ_EN
  // Interrupt register write decode and W1C mask.
  always_comb begin
    wr_istat = dp_wr & (dp_idx == 6'(NWORDS));
    wr_imask = dp_wr & (dp_idx == 6'(NWORDS + 1));
    w1c      = wr_istat ? (HWDATA[NUM_CH-1:0] & wmask[NUM_CH-1:0]) : '0;
  end

  // Interrupt status (hardware set beats W1C), mask and registered irq.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      int_stat_q <= '0;
      int_mask_q <= '0;
      irq        <= 1'b0;
    end else begin
      int_stat_q <= (int_stat_q & ~w1c) | ev;
      if (wr_imask)
        int_mask_q <= (int_mask_q & ~wmask[NUM_CH-1:0]) |
                      (HWDATA[NUM_CH-1:0] & wmask[NUM_CH-1:0]);
      irq <= |(int_stat_q & int_mask_q);
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_dma_ahb_regbank.sv
// tb_dma_ahb_regbank - directed test-plan sequences plus randomized AHB
// traffic checked against a transaction-level register model.
module tb_dma_ahb_regbank;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          NCH  = 4;
  localparam int          SW   = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              hsel, hwrite, hready, hreadyout, hresp, irq;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [31:0]       haddr, hwdata, hrdata;
  logic [NCH-1:0]    ch_en, ch_target, ch_done, ch_err;
  logic [NCH*SW-1:0] ch_size;
  logic [NCH*32-1:0] ch_sour, ch_dest;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [31:0]    m_ctrl [NCH];
  logic [31:0]    m_src  [NCH];
  logic [31:0]    m_dst  [NCH];
  logic [1:0]     m_stat [NCH];
  logic [NCH-1:0] m_istat, m_imask;
  logic [31:0]    last_rd;

  assign hready = hreadyout;
  always #5 clk = ~clk;

  dma_ahb_regbank #(.BASE_ADDR(BASE), .NUM_CH(NCH), .SIZE_W(SW)) dut (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel), .HREADY(hready), .HTRANS(htrans),
    .HSIZE(hsize), .HWRITE(hwrite), .HADDR(haddr), .HWDATA(hwdata),
    .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata),
    .ch_en(ch_en), .ch_target(ch_target), .ch_size(ch_size),
    .ch_sour(ch_sour), .ch_dest(ch_dest), .ch_done(ch_done), .ch_err(ch_err),
    .irq(irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NCH; i++) begin
      m_ctrl[i] = 0; m_src[i] = 0; m_dst[i] = 0; m_stat[i] = 0;
    end
    m_istat = 0; m_imask = 0; last_rd = 0;
  endtask

  function automatic bit m_is_err(input logic [31:0] a, input logic [2:0] sz);
    longint off;
    if (sz > 3'd2) return 1;
    if (sz == 3'd1 && a[0]) return 1;
    if (sz == 3'd2 && a[1:0] != 2'b00) return 1;
    if (a < BASE) return 1;
    off = longint'(a) - longint'(BASE);
    if (off < 16 * NCH) return 0;
`ifdef DMA_REG_IRQ_EN
    if (off < 16 * NCH + 8) return 0;
`endif
    return 1;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int w;
    w = int'((a - BASE) >> 2);
    if (w < 4 * NCH) begin
      case (w % 4)
        0: return m_ctrl[w / 4];
        1: return m_src[w / 4];
        2: return m_dst[w / 4];
        default: return {30'b0, m_stat[w / 4]};
      endcase
    end
`ifdef DMA_REG_IRQ_EN
    if (w == 4 * NCH)     return 32'(m_istat);
    if (w == 4 * NCH + 1) return 32'(m_imask);
`endif
    return 0;
  endfunction

  // One clock edge worth of state change: optional bus write, then engine events.
  task automatic m_commit(input bit wv, input logic [31:0] a, input logic [2:0] sz,
                          input logic [31:0] d, input logic [NCH-1:0] pd, input logic [NCH-1:0] pe);
    logic [31:0]    lanes;
    logic [NCH-1:0] chit;
    int first, nb, w, c;
    lanes = 0;
    chit  = 0;
    if (wv) begin
      first = int'(a[1:0]);
      nb    = 1 << sz;
      for (int b = first; b < first + nb; b++) lanes[8*b +: 8] = 8'hFF;
      w = int'((a - BASE) >> 2);
      if (w < 4 * NCH) begin
        c = w / 4;
        case (w % 4)
          0: begin
            m_ctrl[c] = (m_ctrl[c] & ~lanes) | (d & lanes);
            chit[c] = 1'b1;
            if (first == 0 && d[0]) m_stat[c] = 2'b00;
          end
          1: m_src[c] = (m_src[c] & ~lanes) | (d & lanes);
          2: m_dst[c] = (m_dst[c] & ~lanes) | (d & lanes);
          default: ;
        endcase
      end
`ifdef DMA_REG_IRQ_EN
      else if (w == 4 * NCH)     m_istat = m_istat & ~NCH'(d & lanes);
      else if (w == 4 * NCH + 1) m_imask = NCH'((32'(m_imask) & ~lanes) | (d & lanes));
`endif
    end
    for (int i = 0; i < NCH; i++) begin
      if (pd[i] || pe[i]) begin
        if (!chit[i]) m_ctrl[i][0] = 1'b0;
        m_stat[i] = m_stat[i] | {pe[i], pd[i]};
        m_istat[i] = 1'b1;
      end
    end
  endtask

  task automatic bus_idle();
    hsel = 0; htrans = 2'b00; hwrite = 0; haddr = 0; hsize = 0;
  endtask

  // Single non-pipelined transfer; pulses pd/pe ride along in the data phase.
  task automatic xfer(input string tag, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] d, input logic [NCH-1:0] pd, input logic [NCH-1:0] pe);
    bit err;
    logic [31:0] exp;
    err = m_is_err(a, sz);
    exp = (err || wr) ? 32'h0 : m_read(a);
    @(negedge clk);
    hsel = 1; htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz;
    @(negedge clk);
    bus_idle(); hwdata = d; ch_done = pd; ch_err = pe;
    #1;
    check_eq({tag, "/rdy1"}, 32'(hreadyout), err ? 32'd0 : 32'd1);
    check_eq({tag, "/resp1"}, 32'(hresp), 32'(err));
    if (!wr) begin
      check_eq({tag, "/rdata"}, hrdata, exp);
      last_rd = exp;
    end else begin
      check_eq({tag, "/rhold"}, hrdata, last_rd);
    end
    m_commit(wr && !err, a, sz, d, pd, pe);
    @(negedge clk);
    ch_done = 0; ch_err = 0;
    #1;
    if (err) begin
      check_eq({tag, "/rdy2"}, 32'(hreadyout), 32'd1);
      check_eq({tag, "/resp2"}, 32'(hresp), 32'd1);
      @(negedge clk); #1;
      check_eq({tag, "/resp_ok"}, 32'(hresp), 32'd0);
    end else begin
      check_eq({tag, "/resp_ok"}, 32'(hresp), 32'd0);
    end
  endtask

  // Word write immediately followed by a read (or write) of a2.
  task automatic b2b(input string tag, input logic [31:0] wa, input logic [31:0] wd,
                     input bit second_wr, input logic [31:0] a2);
    int stalls;
    bit exp_stall;
    logic [31:0] exp, wd2;
    exp_stall = !second_wr && (wa[31:2] == a2[31:2]);
    @(negedge clk);
    hsel = 1; htrans = 2'b10; hwrite = 1; haddr = wa; hsize = 3'd2;
    @(negedge clk);
    hwdata = wd; hwrite = second_wr; haddr = a2;
    #1;
    stalls = 0;
    while (hreadyout !== 1'b1 && stalls < 4) begin
      stalls++;
      @(negedge clk); #1;
    end
    check_eq({tag, "/stalls"}, 32'(stalls), 32'(exp_stall));
    m_commit(1, wa, 3'd2, wd, '0, '0);
    @(negedge clk);
    bus_idle();
    if (second_wr) begin
      wd2 = $urandom;
      hwdata = wd2;
      m_commit(1, a2, 3'd2, wd2, '0, '0);
      #1;
      check_eq({tag, "/waw_rdy"}, 32'(hreadyout), 32'd1);
    end else begin
      exp = m_read(a2);
      #1;
      check_eq({tag, "/rdata"}, hrdata, exp);
      last_rd = exp;
    end
  endtask

  task automatic pulse(input logic [NCH-1:0] pd, input logic [NCH-1:0] pe);
    @(negedge clk);
    ch_done = pd; ch_err = pe;
    @(negedge clk);
    ch_done = 0; ch_err = 0;
    m_commit(0, 0, 0, 0, pd, pe);
  endtask

  task automatic check_outs(input string tag);
    logic exp_irq;
    @(negedge clk); #1;
    for (int i = 0; i < NCH; i++) begin
      check_eq($sformatf("%s/en%0d", tag, i), 32'(ch_en[i]), 32'(m_ctrl[i][0]));
      check_eq($sformatf("%s/tg%0d", tag, i), 32'(ch_target[i]), 32'(m_ctrl[i][4]));
      check_eq($sformatf("%s/sz%0d", tag, i), 32'(ch_size[i*SW +: SW]), 32'(m_ctrl[i][8 +: SW]));
      check_eq($sformatf("%s/src%0d", tag, i), ch_sour[i*32 +: 32], m_src[i]);
      check_eq($sformatf("%s/dst%0d", tag, i), ch_dest[i*32 +: 32], m_dst[i]);
    end
`ifdef DMA_REG_IRQ_EN
    exp_irq = |(m_istat & m_imask);
`else
    exp_irq = 1'b0;
`endif
    check_eq({tag, "/irq"}, 32'(irq), 32'(exp_irq));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "/rdy"}, 32'(hreadyout), 32'd1);
    check_eq({tag, "/resp"}, 32'(hresp), 32'd0);
    check_eq({tag, "/rdata"}, hrdata, 32'd0);
    check_eq({tag, "/irq"}, 32'(irq), 32'd0);
    check_eq({tag, "/cfg"}, 32'(|{ch_en, ch_target, ch_size, ch_sour, ch_dest}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [2:0]  sz;
    int sel, lane;
    logic [NCH-1:0] pd, pe;

    rst = 1; bus_idle(); hwdata = 0; ch_done = 0; ch_err = 0;
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    check_reset_state("reset");
    rst = 0;

    // Word write/read of CTRL1 and decoded configuration outputs.
    xfer("w_ctrl1", 1, BASE + 32'h10, 3'd2, 32'h0000_0A11, '0, '0);
    xfer("r_ctrl1", 0, BASE + 32'h10, 3'd2, 0, '0, '0);
    check_eq("ctrl1_val", hrdata, 32'h0000_0A11);
    check_eq("ctrl1_en", 32'(ch_en[1]), 32'd1);
    check_eq("ctrl1_tgt", 32'(ch_target[1]), 32'd1);
    check_eq("ctrl1_size", 32'(ch_size[19:10]), 32'h00A);

    // Byte-lane write, then a misaligned word write that must not land.
    xfer("w_src2", 1, BASE + 32'h24, 3'd2, 32'h1122_3344, '0, '0);
    xfer("wb_src2", 1, BASE + 32'h26, 3'd0, 32'h00AB_0000, '0, '0);
    xfer("r_src2", 0, BASE + 32'h24, 3'd2, 0, '0, '0);
    check_eq("src2_byte", hrdata, 32'h11AB_3344);
    xfer("wmis_src2", 1, BASE + 32'h26, 3'd2, 32'hDEAD_BEEF, '0, '0);
    xfer("r_src2b", 0, BASE + 32'h24, 3'd2, 0, '0, '0);
    check_eq("src2_kept", hrdata, 32'h11AB_3344);

    // Unmapped read, and the first global word.
    xfer("r_unmap", 0, BASE + 32'h50, 3'd2, 0, '0, '0);
    check_eq("unmap_rdata", hrdata, 32'h0);
    xfer("r_glob", 0, BASE + 32'h40, 3'd2, 0, '0, '0);

    // Read-after-write hazard, different word, write-after-write.
    b2b("raw_same", BASE, 32'h1, 0, BASE);
    check_eq("raw_val", hrdata, 32'h1);
    b2b("raw_diff", BASE, 32'h3, 0, BASE + 32'h4);
    b2b("waw", BASE + 32'h8, 32'h55, 1, BASE + 32'h8);

    // Done event on channel 3, interrupt path.
    xfer("w_ctrl3", 1, BASE + 32'h30, 3'd2, 32'h301, '0, '0);
`ifdef DMA_REG_IRQ_EN
    xfer("w_imask", 1, BASE + 32'h44, 3'd2, 32'h8, '0, '0);
`endif
    pulse(4'b1000, 4'b0000);
    #1;
    check_eq("irq_lag", 32'(irq), 32'd0);
    @(negedge clk); #1;
`ifdef DMA_REG_IRQ_EN
    check_eq("irq_set", 32'(irq), 32'd1);
`else
    check_eq("irq_off", 32'(irq), 32'd0);
`endif
    xfer("r_ctrl3", 0, BASE + 32'h30, 3'd2, 0, '0, '0);
    check_eq("ctrl3_done", hrdata, 32'h300);
    xfer("r_stat3", 0, BASE + 32'h3C, 3'd2, 0, '0, '0);
    check_eq("stat3_done", hrdata, 32'h1);
`ifdef DMA_REG_IRQ_EN
    xfer("r_istat", 0, BASE + 32'h40, 3'd2, 0, '0, '0);
    check_eq("istat_set", hrdata, 32'h8);
    xfer("w1c_istat", 1, BASE + 32'h40, 3'd2, 32'h8, '0, 4'b1000);
    xfer("r_istat2", 0, BASE + 32'h40, 3'd2, 0, '0, '0);
    check_eq("istat_hw_wins", hrdata, 32'h8);
`endif

    // CTRL enable write colliding with a done pulse.
    xfer("w_ctrl2_ev", 1, BASE + 32'h20, 3'd2, 32'h5, 4'b0100, '0);
    xfer("r_stat2", 0, BASE + 32'h2C, 3'd2, 0, '0, '0);
    check_eq("stat2_set_wins", hrdata, 32'h1);
    xfer("r_ctrl2", 0, BASE + 32'h20, 3'd2, 0, '0, '0);
    check_eq("ctrl2_bus_wins", hrdata, 32'h5);
    check_outs("dir");

    // Reset while the error response is in its first cycle.
    @(negedge clk);
    hsel = 1; htrans = 2'b10; hwrite = 0; haddr = BASE + 32'h50; hsize = 3'd2;
    @(negedge clk);
    bus_idle();
    #1;
    check_eq("err1_rdy", 32'(hreadyout), 32'd0);
    rst = 1;
    @(negedge clk); #1;
    check_reset_state("rst_err1");
    rst = 0;
    m_reset();
    @(negedge clk); #1;
    check_eq("rst_no_err2", 32'(hresp), 32'd0);

    // Randomized traffic with engine events.
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 14) == 0) begin
        a = BASE + 32'(16 * $urandom_range(0, NCH - 1)) + 32'(4 * $urandom_range(0, 2));
        d = ($urandom_range(0, 1) == 0) ? a
            : BASE + 32'(16 * $urandom_range(0, NCH - 1)) + 32'(4 * $urandom_range(0, 2));
        b2b("rnd_b2b", a, $urandom, $urandom_range(0, 3) == 0, d);
      end else begin
        sel = int'($urandom_range(0, 9));
        if (sel < 8)
          a = BASE + 32'(16 * $urandom_range(0, NCH - 1)) + 32'(4 * $urandom_range(0, 3));
        else if (sel == 8)
          a = BASE + 32'(16 * NCH) + 32'(4 * $urandom_range(0, 3));
        else
          a = ($urandom_range(0, 1) == 0) ? BASE - 32'd4 : BASE + 32'h100;
        sz = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        lane = int'($urandom_range(0, 3));
        if ($urandom_range(0, 3) != 0 && sz != 3'd3) lane = lane & ~((1 << sz) - 1);
        a = a + 32'(lane);
        pd = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
        pe = ($urandom_range(0, 5) == 0) ? NCH'($urandom) : '0;
        xfer("rnd", $urandom_range(0, 1) == 1, a, sz, $urandom, pd, pe);
      end
      if (it % 10 == 9) check_outs("rnd_out");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
